card_select: RTL and testbench
==============================

CARD_SELECT -- requirements
Module: card_select

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 4, sets the consecutive stable cycles required to accept a button level change.
REQ-002 clock  in  1  single system clock; all state updates on rising edge.
REQ-003 reset_n  in  1  asynchronous, active-low reset.
REQ-004 btnUp, btnDown, btnLeft, btnRight, btnSel  in  1 each  raw active-high push-buttons, asynchronous to clock.
REQ-005 matchedMask  in  36  bit i = 1 means card position i is already paired and unselectable.
REQ-006 compBusy  in  1  high while the card comparator is evaluating or displaying a pair.
REQ-007 mem6x6  out  6  cursor position, row*6+col, range 0..35.
REQ-008 A  out  1  one-cycle select strobe to the comparator.
REQ-009 cardOneTwo  out  1  0 = next accepted select is first card, 1 = second card.
REQ-010 firstPick  out  6  position of the accepted first card.
REQ-011 reject  out  1  one-cycle pulse when a select event is refused.

Function
REQ-012 Each button SHALL pass through a 2-flop synchronizer before any other logic.
REQ-013 Each synchronized button SHALL drive a debounce counter; the debounced level SHALL change only after the synchronized sample differs from it for DEBOUNCE_CYCLES consecutive cycles, with the counter clearing on any agreeing sample.
REQ-014 A button event SHALL be a one-cycle pulse on the debounced rising edge; a held button SHALL produce exactly one event.
REQ-015 At most one event SHALL be acted on per cycle, priority Sel > Up > Down > Left > Right; lower-priority simultaneous events are discarded.
REQ-016 Actions SHALL be registered: mem6x6, A, reject and cardOneTwo update on the cycle after the event.
REQ-017 Right SHALL do col+1 with col 5 -> 0 in the same row; Left SHALL do col-1 with 0 -> 5; Down SHALL do row+1 with 5 -> 0; Up SHALL do row-1 with 0 -> 5.
REQ-018 mem6x6 SHALL never leave 0..35.
REQ-019 The FSM states SHALL be PICK1, STROBE1, PICK2, STROBE2 and WAITCMP.
REQ-020 In PICK1, an accepted Sel SHALL set firstPick=mem6x6, pulse A, and go to STROBE1.
REQ-021 STROBE1 SHALL last 1 cycle, then go to PICK2 with cardOneTwo=1.
REQ-022 In PICK2, an accepted Sel SHALL pulse A and go to STROBE2.
REQ-023 STROBE2 SHALL last 1 cycle, then go to WAITCMP.
REQ-024 WAITCMP SHALL last at least 2 cycles and then exit to PICK1, with cardOneTwo=0, on the first cycle compBusy=0.
REQ-025 A Sel event SHALL be rejected, with reject pulsed, A held 0 and state unchanged, if compBusy=1, or matchedMask[mem6x6]=1, or cardOneTwo=1 and mem6x6==firstPick.
REQ-026 A Sel event in WAITCMP SHALL be rejected.
REQ-027 Movement events SHALL be honoured in PICK1, PICK2 and WAITCMP.
REQ-028 Movement events in STROBE1 or STROBE2 SHALL be discarded.
REQ-029 mem6x6 SHALL be held constant in the cycle A=1.
REQ-030 A and reject SHALL never be high in the same cycle.
REQ-031 A SHALL never be high in two consecutive cycles.

Reset
REQ-032 With reset_n=0, outputs SHALL immediately and asynchronously be mem6x6=0, A=0, cardOneTwo=0, firstPick=0 and reject=0.
REQ-033 With reset_n=0, the state SHALL be PICK1, and all synchronizers, debounced levels and counters SHALL be 0.
REQ-034 Reset asserted mid-operation, including during STROBE1 or STROBE2, SHALL drop A in the same cycle and discard any pending selection.
REQ-035 After reset_n rises, a button already held high SHALL produce one event after the normal synchronizer plus debounce latency.

Verification
REQ-036 Reset, then Right x3 and Down x2 (each held 6 cycles) -> mem6x6=15 and A never 1.
REQ-037 From 0, Left then Up -> mem6x6=5, then 35.
REQ-038 At 0, Sel -> A=1 for exactly 1 cycle, firstPick=0, cardOneTwo=1; Sel again at 0 -> reject=1 for 1 cycle, A stays 0.
REQ-039 matchedMask[18]=1 and cursor 18, Sel -> reject pulse, state PICK1; with matchedMask=0, Sel at 18 then Sel at 19 -> two A pulses, state WAITCMP until compBusy=0.
REQ-040 btnSel high for 3 cycles -> no event; btnSel held 100 cycles -> exactly one A pulse; Sel+Right in the same cycle -> select only, cursor unchanged.
REQ-041 reset_n driven low during STROBE2 -> A=0 in that cycle, mem6x6=0, cardOneTwo=0, state PICK1.

Source files
------------

// File: rtl/card_select.sv
// ----------------------------------------------------------------------------
// card_select
//
// Cursor and card-selection front end for a 6x6 memory game. Five raw push
// buttons are synchronized, debounced and turned into single-cycle events.
// Movement events walk a wrapping cursor over the 6x6 grid. Select events
// hand one or two card positions to an external comparator through a
// one-cycle strobe, or are refused with a one-cycle reject pulse.
//
// Ports
//   clock        in   system clock, everything updates on the rising edge
//   reset_n      in   asynchronous active-low reset
//   btnUp/Down/Left/Right/Sel in  raw active-high buttons (asynchronous)
//   matchedMask  in   [35:0] bit i set = card i already paired, unselectable
//   compBusy     in   comparator is evaluating or showing a pair
//   mem6x6       out  [5:0] cursor position row*6+col, 0..35
//   A            out  one-cycle select strobe to the comparator
//   cardOneTwo   out  0 = next accepted select is the first card, 1 = second
//   firstPick    out  [5:0] position of the accepted first card
//   reject       out  one-cycle pulse when a select event is refused
// ----------------------------------------------------------------------------
module card_select #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        btnUp,
    input  logic        btnDown,
    input  logic        btnLeft,
    input  logic        btnRight,
    input  logic        btnSel,
    input  logic [35:0] matchedMask,
    input  logic        compBusy,
    output logic [5:0]  mem6x6,
    output logic        A,
    output logic        cardOneTwo,
    output logic [5:0]  firstPick,
    output logic        reject
);

    // Button vector bit positions, highest index = highest priority.
    localparam int BSEL   = 4;
    localparam int BUP    = 3;
    localparam int BDOWN  = 2;
    localparam int BLEFT  = 1;
    localparam int BRIGHT = 0;

    // The counter only has to reach DEBOUNCE_CYCLES-1; the flip happens on
    // the sample that would complete the run.
    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [2:0] {
        PICK1,
        STROBE1,
        PICK2,
        STROBE2,
        WAITCMP
    } state_t;

    logic [4:0]    rawBtn;
    logic [4:0]    syncA;
    logic [4:0]    syncB;
    logic [4:0]    debLevel;
    logic [4:0]    debPrev;
    logic [CW-1:0] debCnt [5];
    logic [4:0]    btnEvt;

    state_t        stateQ;
    state_t        stateNext;
    logic [2:0]    rowQ;
    logic [2:0]    colQ;
    logic [2:0]    rowNext;
    logic [2:0]    colNext;
    logic [5:0]    firstNext;
    logic          cardNext;
    logic          aNext;
    logic          rejectNext;
    logic          waitDoneQ;
    logic          waitDoneNext;
    logic          selOk;
    logic          canMove;

    assign rawBtn = {btnSel, btnUp, btnDown, btnLeft, btnRight};

    // Two-flop synchronizers, then per-button debounce. The debounced level
    // only follows the synchronized sample after DEBOUNCE_CYCLES disagreeing
    // samples in a row; any agreeing sample restarts the count.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            syncA    <= '0;
            syncB    <= '0;
            debLevel <= '0;
            debPrev  <= '0;
            for (int i = 0; i < 5; i++) begin
                debCnt[i] <= '0;
            end
        end else begin
            syncA   <= rawBtn;
            syncB   <= syncA;
            debPrev <= debLevel;
            for (int i = 0; i < 5; i++) begin
                if (syncB[i] == debLevel[i]) begin
                    debCnt[i] <= '0;
                end else if (debCnt[i] == LAST) begin
                    debLevel[i] <= syncB[i];
                    debCnt[i]   <= '0;
                end else begin
                    debCnt[i] <= debCnt[i] + CW'(1);
                end
            end
        end
    end

    // Rising edge of the debounced level: a held button yields one event.
    assign btnEvt = debLevel & ~debPrev;

    // Cursor is kept as row/col so wrapping is a simple 0..5 modulo.
    assign mem6x6 = ({3'b000, rowQ} * 6'd6) + {3'b000, colQ};

    // A select is refused while the comparator is busy, on a matched card,
    // or when the second pick would be the same card as the first.
    assign selOk = !compBusy && !matchedMask[mem6x6]
                   && !(cardOneTwo && (mem6x6 == firstPick));

    // Cursor is frozen during the strobe cycles so the comparator sees a
    // stable position while A is high.
    assign canMove = (stateQ == PICK1) || (stateQ == PICK2) || (stateQ == WAITCMP);

    // State and all registered outputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            stateQ     <= PICK1;
            rowQ       <= '0;
            colQ       <= '0;
            firstPick  <= '0;
            cardOneTwo <= 1'b0;
            A          <= 1'b0;
            reject     <= 1'b0;
            waitDoneQ  <= 1'b0;
        end else begin
            stateQ     <= stateNext;
            rowQ       <= rowNext;
            colQ       <= colNext;
            firstPick  <= firstNext;
            cardOneTwo <= cardNext;
            A          <= aNext;
            reject     <= rejectNext;
            waitDoneQ  <= waitDoneNext;
        end
    end

    // Next-state and next-output logic. Sel wins over every movement event;
    // among movements Up > Down > Left > Right and the rest are dropped.
    always_comb begin
        stateNext    = stateQ;
        rowNext      = rowQ;
        colNext      = colQ;
        firstNext    = firstPick;
        cardNext     = cardOneTwo;
        aNext        = 1'b0;
        rejectNext   = 1'b0;
        waitDoneNext = waitDoneQ;

        unique case (stateQ)
            PICK1: begin
                if (btnEvt[BSEL]) begin
                    if (selOk) begin
                        firstNext = mem6x6;
                        aNext     = 1'b1;
                        cardNext  = 1'b1;
                        stateNext = STROBE1;
                    end else begin
                        rejectNext = 1'b1;
                    end
                end
            end
            STROBE1: begin
                stateNext  = PICK2;
                rejectNext = btnEvt[BSEL];
            end
            PICK2: begin
                if (btnEvt[BSEL]) begin
                    if (selOk) begin
                        aNext     = 1'b1;
                        stateNext = STROBE2;
                    end else begin
                        rejectNext = 1'b1;
                    end
                end
            end
            STROBE2: begin
                stateNext    = WAITCMP;
                waitDoneNext = 1'b0;
                rejectNext   = btnEvt[BSEL];
            end
            WAITCMP: begin
                // The first WAITCMP cycle only arms waitDone, so the
                // comparator always gets at least two cycles.
                waitDoneNext = 1'b1;
                rejectNext   = btnEvt[BSEL];
                if (waitDoneQ && !compBusy) begin
                    stateNext = PICK1;
                    cardNext  = 1'b0;
                end
            end
            default: begin
                stateNext = PICK1;
                cardNext  = 1'b0;
            end
        endcase

        if (!btnEvt[BSEL] && canMove) begin
            if (btnEvt[BUP]) begin
                rowNext = (rowQ == 3'd0) ? 3'd5 : rowQ - 3'd1;
            end else if (btnEvt[BDOWN]) begin
                rowNext = (rowQ == 3'd5) ? 3'd0 : rowQ + 3'd1;
            end else if (btnEvt[BLEFT]) begin
                colNext = (colQ == 3'd0) ? 3'd5 : colQ - 3'd1;
            end else if (btnEvt[BRIGHT]) begin
                colNext = (colQ == 3'd5) ? 3'd0 : colQ + 3'd1;
            end
        end
    end

endmodule

// File: tb/tb_card_select.sv
// ----------------------------------------------------------------------------
// tb_card_select
//
// Bench for card_select: a table of directed button presses with expected
// cursor/pick/strobe results, hand-written multi-cycle sequences for the
// waiting, reset and long-hold corners, then random presses checked against
// a grid-level model of the game rules.
// ----------------------------------------------------------------------------
module tb_card_select;

    localparam logic [4:0] SEL   = 5'b10000;
    localparam logic [4:0] UP    = 5'b01000;
    localparam logic [4:0] DOWN  = 5'b00100;
    localparam logic [4:0] LEFT  = 5'b00010;
    localparam logic [4:0] RIGHT = 5'b00001;

    logic        clock;
    logic        reset_n;
    logic        btnUp;
    logic        btnDown;
    logic        btnLeft;
    logic        btnRight;
    logic        btnSel;
    logic [35:0] matchedMask;
    logic        compBusy;
    logic [5:0]  mem6x6;
    logic        A;
    logic        cardOneTwo;
    logic [5:0]  firstPick;
    logic        reject;

    int vectors = 0;
    int errors  = 0;
    int aCount  = 0;
    int rejCount = 0;
    int protoViol = 0;
    logic prevA = 1'b0;

    typedef struct {
        logic [4:0] btns;
        logic       busy;
        int         maskPos;
        int         expMem;
        int         expA;
        int         expRej;
        int         expCard;
        int         expFirst;
    } vec_t;

    vec_t tbl[$];

    card_select #(.DEBOUNCE_CYCLES(4)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .btnUp      (btnUp),
        .btnDown    (btnDown),
        .btnLeft    (btnLeft),
        .btnRight   (btnRight),
        .btnSel     (btnSel),
        .matchedMask(matchedMask),
        .compBusy   (compBusy),
        .mem6x6     (mem6x6),
        .A          (A),
        .cardOneTwo (cardOneTwo),
        .firstPick  (firstPick),
        .reject     (reject)
    );

    // Free-running clock, period 10.
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Pulse counters and protocol watch, sampled away from the active edge.
    always @(negedge clock) begin
        if (A) aCount++;
        if (reject) rejCount++;
        if (A && reject) protoViol++;
        if (A && prevA) protoViol++;
        if (mem6x6 > 6'd35) protoViol++;
        prevA <= A;
    end

    // Hard stop in case a sequence never completes.
    initial begin
        #500000;
        $display("[TB] FAIL timeout: simulation did not reach the summary");
        $fatal(1, "[TB] timeout");
    end

    function automatic vec_t mk(logic [4:0] b, logic bz, int mp, int m,
                                int a, int r, int c, int f);
        vec_t v;
        v.btns = b; v.busy = bz; v.maskPos = mp; v.expMem = m;
        v.expA = a; v.expRej = r; v.expCard = c; v.expFirst = f;
        return v;
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        vectors++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic setButtons(input logic [4:0] b);
        {btnSel, btnUp, btnDown, btnLeft, btnRight} = b;
    endtask

    // Press the given buttons for 'hold' clock edges, then release for 'rel'.
    task automatic applyStimulus(input logic [4:0] b, input int hold, input int rel);
        @(negedge clock);
        setButtons(b);
        repeat (hold) @(negedge clock);
        setButtons(5'b0);
        repeat (rel) @(negedge clock);
    endtask

    task automatic doReset();
        @(negedge clock);
        reset_n = 1'b0;
        setButtons(5'b0);
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        repeat (2) @(negedge clock);
    endtask

    // Wait for the strobe with the button held; bounded.
    task automatic waitForA(input string name);
        bit seen = 0;
        for (int i = 0; i < 30 && !seen; i++) begin
            @(negedge clock);
            if (A) seen = 1;
        end
        checkOutput(name, int'(seen), 1);
    endtask

    task automatic checkState(input string tag, input int m, input int c, input int f);
        checkOutput({tag, ".mem"}, int'(mem6x6), m);
        checkOutput({tag, ".card"}, int'(cardOneTwo), c);
        checkOutput({tag, ".first"}, int'(firstPick), f);
    endtask

    initial begin
        int a0;
        int r0;
        int mCur;
        int mFirst;
        int mPhase;
        int mA;
        int mRej;
        int row;
        int col;
        logic [63:0] rm;
        logic [4:0] b;
        logic bz;

        reset_n = 1'b1;
        setButtons(5'b0);
        matchedMask = '0;
        compBusy = 1'b0;

        // Asynchronous reset values, checked before any clock edge matters.
        #2 reset_n = 1'b0;
        #1;
        checkOutput("reset.mem", int'(mem6x6), 0);
        checkOutput("reset.A", int'(A), 0);
        checkOutput("reset.card", int'(cardOneTwo), 0);
        checkOutput("reset.first", int'(firstPick), 0);
        checkOutput("reset.reject", int'(reject), 0);
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        repeat (2) @(negedge clock);

        // Directed table: movement with wrap, selects, rejects, mask.
        tbl.push_back(mk(RIGHT, 0, -1,  1, 0, 0, 0,  0));
        tbl.push_back(mk(RIGHT, 0, -1,  2, 0, 0, 0,  0));
        tbl.push_back(mk(RIGHT, 0, -1,  3, 0, 0, 0,  0));
        tbl.push_back(mk(DOWN,  0, -1,  9, 0, 0, 0,  0));
        tbl.push_back(mk(DOWN,  0, -1, 15, 0, 0, 0,  0));
        tbl.push_back(mk(UP,    0, -1,  9, 0, 0, 0,  0));
        tbl.push_back(mk(UP,    0, -1,  3, 0, 0, 0,  0));
        tbl.push_back(mk(LEFT,  0, -1,  2, 0, 0, 0,  0));
        tbl.push_back(mk(LEFT,  0, -1,  1, 0, 0, 0,  0));
        tbl.push_back(mk(LEFT,  0, -1,  0, 0, 0, 0,  0));
        tbl.push_back(mk(LEFT,  0, -1,  5, 0, 0, 0,  0));
        tbl.push_back(mk(UP,    0, -1, 35, 0, 0, 0,  0));
        tbl.push_back(mk(DOWN,  0, -1,  5, 0, 0, 0,  0));
        tbl.push_back(mk(RIGHT, 0, -1,  0, 0, 0, 0,  0));
        tbl.push_back(mk(SEL,   0, -1,  0, 1, 0, 1,  0));
        tbl.push_back(mk(SEL,   0, -1,  0, 0, 1, 1,  0));
        tbl.push_back(mk(RIGHT, 0, -1,  1, 0, 0, 1,  0));
        tbl.push_back(mk(SEL,   0, -1,  1, 1, 0, 0,  0));
        tbl.push_back(mk(LEFT,  0, -1,  0, 0, 0, 0,  0));
        tbl.push_back(mk(DOWN,  0, -1,  6, 0, 0, 0,  0));
        tbl.push_back(mk(DOWN,  0, -1, 12, 0, 0, 0,  0));
        tbl.push_back(mk(DOWN,  0, -1, 18, 0, 0, 0,  0));
        tbl.push_back(mk(SEL,   0, 18, 18, 0, 1, 0,  0));
        tbl.push_back(mk(SEL,   0, -1, 18, 1, 0, 1, 18));
        tbl.push_back(mk(RIGHT, 0, -1, 19, 0, 0, 1, 18));
        tbl.push_back(mk(SEL,   0, -1, 19, 1, 0, 0, 18));
        tbl.push_back(mk(SEL,   1, -1, 19, 0, 1, 0, 18));

        foreach (tbl[i]) begin
            @(negedge clock);
            compBusy = tbl[i].busy;
            matchedMask = (tbl[i].maskPos >= 0) ? (36'd1 << tbl[i].maskPos) : 36'd0;
            a0 = aCount;
            r0 = rejCount;
            applyStimulus(tbl[i].btns, 6, 10);
            checkOutput($sformatf("tbl%0d.mem", i), int'(mem6x6), tbl[i].expMem);
            checkOutput($sformatf("tbl%0d.A", i), aCount - a0, tbl[i].expA);
            checkOutput($sformatf("tbl%0d.reject", i), rejCount - r0, tbl[i].expRej);
            checkOutput($sformatf("tbl%0d.card", i), int'(cardOneTwo), tbl[i].expCard);
            checkOutput($sformatf("tbl%0d.first", i), int'(firstPick), tbl[i].expFirst);
        end
        compBusy = 1'b0;
        matchedMask = '0;

        // Short glitch on Sel is filtered; a long hold gives one strobe.
        a0 = aCount; r0 = rejCount;
        applyStimulus(SEL, 3, 10);
        checkOutput("short.A", aCount - a0, 0);
        checkOutput("short.reject", rejCount - r0, 0);
        a0 = aCount;
        applyStimulus(SEL, 100, 10);
        checkOutput("long.A", aCount - a0, 1);
        checkState("long", 19, 1, 19);
        applyStimulus(RIGHT, 6, 10);
        a0 = aCount;
        applyStimulus(SEL | RIGHT, 6, 10);
        checkOutput("selright.A", aCount - a0, 1);
        checkState("selright", 20, 0, 19);

        // Comparator stays busy: remain waiting, refuse Sel, still move.
        applyStimulus(SEL, 6, 10);
        applyStimulus(LEFT, 6, 10);
        checkState("wait.pre", 19, 1, 20);
        @(negedge clock);
        btnSel = 1'b1;
        waitForA("wait.strobe");
        compBusy = 1'b1;
        btnSel = 1'b0;
        repeat (20) @(negedge clock);
        checkOutput("wait.held", int'(cardOneTwo), 1);
        r0 = rejCount; a0 = aCount;
        applyStimulus(SEL, 6, 10);
        checkOutput("wait.reject", rejCount - r0, 1);
        checkOutput("wait.noA", aCount - a0, 0);
        applyStimulus(RIGHT, 6, 10);
        checkState("wait.move", 20, 1, 20);
        compBusy = 1'b0;
        repeat (3) @(negedge clock);
        checkOutput("wait.exit", int'(cardOneTwo), 0);

        // Reset asserted in the second strobe cycle.
        applyStimulus(SEL, 6, 10);
        applyStimulus(LEFT, 6, 10);
        @(negedge clock);
        btnSel = 1'b1;
        waitForA("rst.strobe");
        #1 reset_n = 1'b0;
        #1;
        checkOutput("rst.A", int'(A), 0);
        checkState("rst", 0, 0, 0);
        btnSel = 1'b0;
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        repeat (10) @(negedge clock);
        a0 = aCount;
        applyStimulus(SEL, 6, 10);
        checkOutput("rst.after.A", aCount - a0, 1);
        checkState("rst.after", 0, 1, 0);

        // A button held through reset release yields exactly one move.
        @(negedge clock);
        reset_n = 1'b0;
        btnRight = 1'b1;
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        repeat (12) @(negedge clock);
        btnRight = 1'b0;
        repeat (10) @(negedge clock);
        checkOutput("heldrst.mem", int'(mem6x6), 1);

        // Random presses against a grid-level model of the rules.
        doReset();
        mCur = 0; mFirst = 0; mPhase = 0;
        for (int n = 0; n < 120; n++) begin
            case ($urandom_range(0, 7))
                3: b = UP;
                4: b = DOWN;
                5: b = LEFT;
                6: b = RIGHT;
                default: b = SEL;
            endcase
            bz = ($urandom_range(0, 3) == 0);
            rm = {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
            @(negedge clock);
            compBusy = bz;
            matchedMask = rm[35:0];
            a0 = aCount; r0 = rejCount;
            mA = 0; mRej = 0;
            if (mPhase == 2 && !bz) mPhase = 0;
            row = mCur / 6;
            col = mCur % 6;
            if (b == SEL) begin
                if (bz || mPhase == 2 || rm[mCur] || (mPhase == 1 && mCur == mFirst)) begin
                    mRej = 1;
                end else begin
                    mA = 1;
                    if (mPhase == 0) begin
                        mFirst = mCur;
                        mPhase = 1;
                    end else begin
                        mPhase = 2;
                    end
                end
            end else if (b == UP) begin
                row = (row + 5) % 6;
            end else if (b == DOWN) begin
                row = (row + 1) % 6;
            end else if (b == LEFT) begin
                col = (col + 5) % 6;
            end else begin
                col = (col + 1) % 6;
            end
            mCur = row * 6 + col;
            if (mPhase == 2 && !bz) mPhase = 0;
            applyStimulus(b, $urandom_range(6, 10), $urandom_range(10, 14));
            checkOutput($sformatf("rnd%0d.mem", n), int'(mem6x6), mCur);
            checkOutput($sformatf("rnd%0d.first", n), int'(firstPick), mFirst);
            checkOutput($sformatf("rnd%0d.card", n), int'(cardOneTwo), (mPhase != 0) ? 1 : 0);
            checkOutput($sformatf("rnd%0d.A", n), aCount - a0, mA);
            checkOutput($sformatf("rnd%0d.reject", n), rejCount - r0, mRej);
        end

        checkOutput("protocol", protoViol, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
